// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the pipeline's MW-stage load/store port.
// Optional DMEM_ALIGN_CHECK_EN: flag misaligned accesses with resp_err and suppress their effect.
module dmem_responder #(
    parameter int unsigned ADDR_BITS = 10,
    parameter int unsigned LATENCY   = 2,
    parameter logic [31:0] BASE_ADDR = 32'h1001_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_read,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int unsigned DEPTH = 2 ** ADDR_BITS;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t                 state;
    logic [CNT_W-1:0]       count;
    logic [31:0]            mem [DEPTH];

    // Holding registers for the accepted request
    logic                   op_store;
    logic                   op_load;
    logic                   op_err;
    logic [ADDR_BITS-1:0]   op_idx;
    logic [31:0]            op_wdata;

    logic [31:0]            offset;
    logic [ADDR_BITS-1:0]   req_idx;
    logic                   req_misaligned;
    logic                   accept;
    logic                   enter_resp;
    logic                   cur_load;
    logic                   cur_err;
    logic [ADDR_BITS-1:0]   cur_idx;
    logic                   unused_offset_bits;

    assign offset  = req_addr - BASE_ADDR;
    assign req_idx = offset[ADDR_BITS+1:2];
    assign accept  = req_valid & req_ready;
    assign unused_offset_bits = ^{offset[31:ADDR_BITS+2], offset[1:0]};

`ifdef DMEM_ALIGN_CHECK_EN
    assign req_misaligned = |req_addr[1:0];
`else
    assign req_misaligned = 1'b0;
`endif

    // RESP is entered straight from IDLE only in the single-cycle build
    always_comb begin
        enter_resp = 1'b0;
        if (state == IDLE && accept && LATENCY == 1) begin
            enter_resp = 1'b1;
        end else if (state == WAIT && count == CNT_W'(1)) begin
            enter_resp = 1'b1;
        end
    end

    // Access descriptor used at RESP entry: live request from IDLE, held copy otherwise
    always_comb begin
        cur_load = op_load;
        cur_err  = op_err;
        cur_idx  = op_idx;
        if (state == IDLE) begin
            cur_load = req_read & ~req_write;
            cur_err  = req_misaligned;
            cur_idx  = req_idx;
        end
    end

    // Control FSM with registered handshake and response outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            count      <= '0;
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            op_store   <= 1'b0;
            op_load    <= 1'b0;
            op_err     <= 1'b0;
            op_idx     <= '0;
            op_wdata   <= '0;
        end else begin
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        op_store <= req_write;
                        op_load  <= req_read & ~req_write;
                        op_err   <= req_misaligned;
                        op_idx   <= req_idx;
                        op_wdata <= req_wdata;
                        if (LATENCY > 1) begin
                            state <= WAIT;
                            count <= CNT_W'(LATENCY - 1);
                        end else begin
                            state <= RESP;
                        end
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                WAIT: begin
                    count <= count - CNT_W'(1);
                    if (count == CNT_W'(1)) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
            if (enter_resp) begin
                resp_valid <= 1'b1;
                resp_err   <= cur_err;
                resp_rdata <= (cur_load && !cur_err) ? mem[cur_idx] : 32'h0;
            end
        end
    end

    // Word array; stores commit on the edge that leaves RESP
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (state == RESP && op_store && !op_err) begin
            mem[op_idx] <= op_wdata;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: LATENCY=2 instance for the main flows, LATENCY=1 instance for back-to-back timing.
module tb_dmem_responder;

    localparam int unsigned LAT = 2;

`ifdef DMEM_ALIGN_CHECK_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_read, req_write;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;

    logic        r1_valid, r1_ready, r1_read, r1_write;
    logic [31:0] r1_addr, r1_wdata;
    logic        r1_resp_valid, r1_resp_err;
    logic [31:0] r1_resp_rdata;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_responder #(.ADDR_BITS(10), .LATENCY(LAT), .BASE_ADDR(32'h1001_0000)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_read(req_read), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    dmem_responder #(.ADDR_BITS(10), .LATENCY(1), .BASE_ADDR(32'h1001_0000)) dut_l1 (
        .clk(clk), .reset(reset),
        .req_valid(r1_valid), .req_ready(r1_ready), .req_read(r1_read), .req_write(r1_write),
        .req_addr(r1_addr), .req_wdata(r1_wdata),
        .resp_valid(r1_resp_valid), .resp_rdata(r1_resp_rdata), .resp_err(r1_resp_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Response monitor: pops the scoreboard on each resp_valid pulse
    always @(negedge clk) begin
        if (resp_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check_eq("unexpected_resp", 32'(sb.size()), 32'd1);
            end else begin
                mon_e = sb.pop_front();
                check_eq("rdata", resp_rdata, mon_e.rdata);
                check_eq("err", 32'(resp_err), 32'(mon_e.err));
                check_eq("latency", 32'(cyc - mon_e.cyc), 32'(LAT));
            end
        end else if (resp_rdata !== 32'h0 || resp_err !== 1'b0) begin
            check_eq("idle_outputs", resp_rdata | 32'(resp_err), 32'h0);
        end
    end

    task automatic send(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rdata,
                        input logic exp_err, input bit expect_resp);
        int n = 0;
        exp_t e;
        @(negedge clk);
        req_valid = 1'b1;
        req_read  = rd;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        while (req_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (req_ready !== 1'b1) begin
            check_eq("ready_timeout", 32'(req_ready), 32'd1);
        end else if (expect_resp) begin
            e.rdata = exp_rdata;
            e.err   = exp_err;
            e.cyc   = cyc;
            sb.push_back(e);
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            check_eq("drain_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    initial begin
        int   n;
        exp_t e;
        reset = 1'b0;
        req_valid = 1'b0; req_read = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        r1_valid = 1'b0; r1_read = 1'b0; r1_write = 1'b0; r1_addr = 32'h1001_0000; r1_wdata = '0;

        // Reset held three cycles
        repeat (3) begin
            @(negedge clk);
            check_eq("rst_ready", 32'(req_ready), 32'd0);
            check_eq("rst_valid", 32'(resp_valid), 32'd0);
            check_eq("rst_rdata", resp_rdata, 32'h0);
        end
        reset = 1'b1;

        // Store/load round trip
        send(1'b0, 1'b1, 32'h1001_0008, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b1);
        drain();
        send(1'b1, 1'b0, 32'h1001_0008, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b1);
        drain();

        // req_valid held through WAIT with a changed address
        @(negedge clk);
        req_valid = 1'b1; req_read = 1'b1; req_write = 1'b0; req_addr = 32'h1001_0008;
        n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("hold_first_ready", 32'(req_ready), 32'd1);
        e.rdata = 32'hDEAD_BEEF; e.err = 1'b0; e.cyc = cyc;
        sb.push_back(e);
        @(posedge clk);
        #1;
        req_read = 1'b0; req_write = 1'b1; req_addr = 32'h1001_000C; req_wdata = 32'h1234_5678;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (req_ready !== 1'b1 && n < 20);
        check_eq("hold_accept_gap", 32'(n), 32'(LAT + 1));
        e.rdata = 32'h0; e.err = 1'b0; e.cyc = cyc;
        sb.push_back(e);
        @(posedge clk);
        #1 req_valid = 1'b0;
        drain();
        send(1'b1, 1'b0, 32'h1001_000C, 32'h0, 32'h1234_5678, 1'b0, 1'b1);
        drain();

        // Out-of-range address aliases onto word 0
        send(1'b0, 1'b1, 32'h1001_1000, 32'h11, 32'h0, 1'b0, 1'b1);
        drain();
        send(1'b1, 1'b0, 32'h1001_0000, 32'h0, 32'h11, 1'b0, 1'b1);
        drain();

        // No-op request is still answered
        send(1'b0, 1'b0, 32'h1001_0000, 32'h0, 32'h0, 1'b0, 1'b1);
        drain();

        // Reset during WAIT aborts the store
        send(1'b0, 1'b1, 32'h1001_0004, 32'h5, 32'h0, 1'b0, 1'b0);
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_eq("abort_valid", 32'(resp_valid), 32'd0);
        end
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_eq("abort_no_resp", 32'(resp_valid), 32'd0);
        end
        send(1'b1, 1'b0, 32'h1001_0004, 32'h0, 32'h0, 1'b0, 1'b1);
        drain();

        // Misaligned store on a freshly cleared array
        send(1'b0, 1'b1, 32'h1001_0002, 32'h7, 32'h0, ALIGN_EN, 1'b1);
        drain();
        send(1'b1, 1'b0, 32'h1001_0000, 32'h0, ALIGN_EN ? 32'h0 : 32'h7, 1'b0, 1'b1);
        drain();

        // Single-cycle instance: back-to-back loads
        @(negedge clk);
        r1_valid = 1'b1; r1_read = 1'b1;
        n = 0;
        while (r1_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("l1_first_ready", 32'(r1_ready), 32'd1);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check_eq("l1_ready", 32'(r1_ready), 32'(k % 2 == 0));
            check_eq("l1_valid", 32'(r1_resp_valid), 32'(k % 2 == 1));
            check_eq("l1_rdata", r1_resp_rdata, 32'h0);
        end
        r1_valid = 1'b0;
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
